sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Sequences and shares one 64x32 single-port SRAM macro (active-low CEB/WEB, 1-cycle read latency, Q undefined on non-read cycles) between one read requester and one write requester.
- Round-robin arbitrates the single port and captures macro Q into a 2-entry response FIFO with valid/ready backpressure.
- Optionally zero-fills the array after reset before granting requesters.
- Sits between cache/predictor table logic and the SRAM macro wrapper.

Parameters:
- ADDR_W, 6, address width.
- DATA_W, 32, data width.
- DEPTH, 64, number of words; must equal 2**ADDR_W.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted when rd_valid & rd_ready.
- rd_addr  in  ADDR_W  read address.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted when wr_valid & wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer accepts resp_data.
- resp_data  out  DATA_W  read data, in request order.
- init_done  out  1  high once the array may be used.
- sram_ceb  out  1  macro chip enable, active low.
- sram_web  out  1  macro write enable, active low (0 = write).
- sram_a  out  ADDR_W  macro address.
- sram_d  out  DATA_W  macro write data.
- sram_q  in  DATA_W  macro read data, valid only the cycle after a read.

Behaviour:
- States: INIT, RUN. Reset enters INIT; with the init feature compiled out, it enters RUN.
- While reset is high: sram_ceb=1, sram_web=1, sram_a=0, sram_d=0, rd_ready=0, wr_ready=0, resp_valid=0, init_done=0, FIFO empty, in-flight flag cleared, RR pointer = read-first.
- INIT:
  - Each cycle writes 0 to address init_cnt (ceb=0, web=0). init_cnt runs 0..DEPTH-1.
  - After the write to DEPTH-1, go to RUN. That is exactly DEPTH cycles.
  - rd_ready=wr_ready=0 throughout.
- RUN:
  - init_done=1.
  - SRAM port outputs are combinational from the grant.
- Read eligibility: rd_ok = (inflight + fifo_count - (resp_valid & resp_ready)) < 2.
- Arbitration:
  - Only wr_valid: grant write.
  - Only rd_valid & rd_ok: grant read.
  - Both eligible: grant the side opposite last_grant; last_grant updates on every grant.
  - rd_valid without rd_ok: write may be granted.
- rd_ready = grant_rd and wr_ready = grant_wr, computed combinationally; the same cycle's valid never depends on ready.
- Write grant: ceb=0, web=0, a=wr_addr, d=wr_data.
- Read grant: ceb=0, web=1, a=rd_addr. Set inflight for the next cycle.
- No grant: ceb=1, web=1; a and d hold 0.
- Read latency: accept at cycle T; at end of T+1, sram_q is pushed to the FIFO; resp_valid rises in T+2.
  - Full throughput of one read per cycle when resp_ready is held high.
- FIFO:
  - 2 entries, in order.
  - Push and pop in the same cycle are legal when occupancy is 1 or 2.
  - Credit rule makes overflow impossible. Overflow is an assertion failure.
- Write followed by read of the same address in the next cycle returns the new data; the macro is write-first at the edge.
- Reset mid-operation: in-flight read and FIFO contents are discarded with no response; INIT restarts from address 0.

Optional Feature:
- Macro SRAM_PORT_ARBITER_INIT_EN.
- Defined: INIT zero-fill as above; init_done rises after DEPTH cycles.
- Undefined: no INIT state or counter. RUN is entered on the first cycle after reset deasserts, with init_done=1. Reads of never-written addresses return undefined data.

Decomposition:
- Package sram_arb_pkg holds:
  - State enum (INIT, RUN).
  - Default ADDR_W/DATA_W/DEPTH constants.
  - Grant encoding (NONE, RD, WR).
- One sub-module, sram_resp_fifo: 2-entry valid/ready FIFO, DATA_W wide, exposing count.
- Arbiter, credit logic and INIT sequencer stay in the top.

Test Plan:
- Init sweep (feature on): release reset, then read addresses 0, 17 and 63 -> init_done after 64 cycles; each resp_data = 0x00000000; no grants during INIT.
- Write 0xDEADBEEF to addr 5 at cycle T, read addr 5 at T+1 -> resp_valid at T+3 with 0xDEADBEEF.
- Both valid every cycle (rd addr 3, wr addr 9, resp_ready=1) -> grants alternate RD, WR, RD, WR starting with RD after reset.
- resp_ready=0, 4 back-to-back reads -> exactly 2 accepted, rd_ready=0 afterwards. Raise resp_ready -> remaining reads drain in order with correct data.
- Writes keep flowing while reads stall: FIFO full, wr_valid=1 -> every cycle grants WR.
- Assert reset with 1 read in flight and 1 FIFO entry -> no resp_valid after reset; INIT restarts at address 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared sizing defaults, FSM states and grant encoding for the SRAM port arbiter.
package sram_arb_pkg;

    localparam int ARB_ADDR_W = 6;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_DEPTH  = 64;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry in-order response FIFO with valid/ready output; holds SRAM read data
// until the consumer takes it.
module sram_resp_fifo
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pop_eff;

    assign pop_eff   = pop & (count_q != 2'd0);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_eff) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop_eff})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Payload storage needs no reset; only the pointers and occupancy do.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assert property (@(posedge clock) disable iff (reset)
                     !(push && !pop_eff && (count_q == 2'd2)));

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM between a reader and a writer, with a
// credit-limited 2-entry response FIFO. Define SRAM_PORT_ARBITER_INIT_EN to zero-fill after reset.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int DEPTH  = ARB_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("sram_port_arbiter: DEPTH must equal 2**ADDR_W");
    end

`ifdef SRAM_PORT_ARBITER_INIT_EN
    localparam arb_state_e RESET_STATE = ST_INIT;
`else
    localparam arb_state_e RESET_STATE = ST_RUN;
`endif

    arb_state_e        state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic              inflight_q, inflight_d;
`ifdef SRAM_PORT_ARBITER_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
`endif

    grant_e            grant;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        fifo_count;
    logic              pop;
    logic [2:0]        occupancy;
    logic              rd_ok;

    sram_resp_fifo #(
        .DATA_W(DATA_W)
    ) u_resp_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (inflight_q),
        .push_data(sram_q),
        .pop      (pop),
        .out_valid(fifo_valid),
        .out_data (fifo_data),
        .count    (fifo_count)
    );

    // A read may only launch if its response is guaranteed a FIFO slot, counting
    // the read already in the macro pipeline and any entry leaving this cycle.
    always_comb begin
        resp_valid = fifo_valid & ~reset;
        resp_data  = fifo_data;
        pop        = resp_valid & resp_ready;
        occupancy  = {2'b00, inflight_q} + {1'b0, fifo_count} - {2'b00, pop};
        rd_ok      = (occupancy < 3'd2);
    end

    always_comb begin
        grant = GNT_NONE;
        if (!reset && (state_q == ST_RUN)) begin
            if (wr_valid && rd_valid && rd_ok) begin
                grant = last_wr_q ? GNT_RD : GNT_WR;
            end else if (rd_valid && rd_ok) begin
                grant = GNT_RD;
            end else if (wr_valid) begin
                grant = GNT_WR;
            end
        end
    end

    always_comb begin
        rd_ready  = (grant == GNT_RD);
        wr_ready  = (grant == GNT_WR);
        init_done = !reset && (state_q == ST_RUN);
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        unique case (grant)
            GNT_WR: begin
                sram_ceb = 1'b0;
                sram_web = 1'b0;
                sram_a   = wr_addr;
                sram_d   = wr_data;
            end
            GNT_RD: begin
                sram_ceb = 1'b0;
                sram_a   = rd_addr;
            end
            default: ;
        endcase
`ifdef SRAM_PORT_ARBITER_INIT_EN
        if (!reset && (state_q == ST_INIT)) begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = init_cnt_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        inflight_d = (grant == GNT_RD);
        if (grant != GNT_NONE) begin
            last_wr_d = (grant == GNT_WR);
        end
`ifdef SRAM_PORT_ARBITER_INIT_EN
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
`endif
    end

    // last_wr starts set so the first contested cycle after reset goes to the reader.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            last_wr_q  <= 1'b1;
            inflight_q <= 1'b0;
`ifdef SRAM_PORT_ARBITER_INIT_EN
            init_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_wr_q  <= last_wr_d;
            inflight_q <= inflight_d;
`ifdef SRAM_PORT_ARBITER_INIT_EN
            init_cnt_q <= init_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed, table-driven bench for sram_port_arbiter with a behavioural write-first SRAM.
// Honours SRAM_PORT_ARBITER_INIT_EN for the init sweep and restart checks.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int          ADDR_W = 6;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] Q_JUNK = 32'hBAAD_F00D;
    localparam logic [31:0] PRELOAD_BASE = 32'hA5A5_0000;

`ifdef SRAM_PORT_ARBITER_INIT_EN
    localparam logic [31:0] MEM3 = 32'h0000_0000;
`else
    localparam logic [31:0] MEM3 = PRELOAD_BASE | 32'd3;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              rd_valid = 1'b0;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_data;
    logic              init_done;
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    int    checks = 0;
    int    errors = 0;
    string cur_test = "reset";

    always #5 clock = ~clock;

    sram_port_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .init_done (init_done),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // Macro model: preloaded with a nonzero pattern so zero-fill is observable,
    // and Q carries junk on every cycle that does not follow a read.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_loaded = 1'b0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PRELOAD_BASE | 32'(i);
            mem_loaded <= 1'b1;
        end else if (!sram_ceb && !sram_web) begin
            mem[sram_a] <= sram_d;
        end
        sram_q <= (!sram_ceb && sram_web) ? mem[sram_a] : Q_JUNK;
    end

    typedef struct packed {
        logic              rd_valid;
        logic [ADDR_W-1:0] rd_addr;
        logic              wr_valid;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              resp_ready;
        grant_e            exp_gnt;
        logic              exp_resp_valid;
        logic [DATA_W-1:0] exp_resp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rv, input logic [ADDR_W-1:0] ra,
                                input logic wv, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input logic rr,
                                input grant_e g, input logic ev, input logic [DATA_W-1:0] ed);
        vec_t v;
        v.rd_valid       = rv;
        v.rd_addr        = ra;
        v.wr_valid       = wv;
        v.wr_addr        = wa;
        v.wr_data        = wd;
        v.resp_ready     = rr;
        v.exp_gnt        = g;
        v.exp_resp_valid = ev;
        v.exp_resp_data  = ed;
        return v;
    endfunction

    task automatic check_val(input string name, input int step,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s step %0d: got %h expected %h", cur_test, name, step, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        rd_valid   = v.rd_valid;
        rd_addr    = v.rd_addr;
        wr_valid   = v.wr_valid;
        wr_addr    = v.wr_addr;
        wr_data    = v.wr_data;
        resp_ready = v.resp_ready;
    endtask

    task automatic checkOutput(input vec_t v, input int step);
        #1;
        check_val("rd_ready", step, 32'(rd_ready), 32'(v.exp_gnt == GNT_RD));
        check_val("wr_ready", step, 32'(wr_ready), 32'(v.exp_gnt == GNT_WR));
        check_val("sram_ceb", step, 32'(sram_ceb), 32'(v.exp_gnt == GNT_NONE));
        if (v.exp_gnt != GNT_NONE) begin
            check_val("sram_web", step, 32'(sram_web), 32'(v.exp_gnt == GNT_RD));
            check_val("sram_a", step, 32'(sram_a),
                      32'((v.exp_gnt == GNT_RD) ? v.rd_addr : v.wr_addr));
        end
        if (v.exp_gnt == GNT_WR) begin
            check_val("sram_d", step, sram_d, v.wr_data);
        end
        check_val("resp_valid", step, 32'(resp_valid), 32'(v.exp_resp_valid));
        if (v.exp_resp_valid) begin
            check_val("resp_data", step, resp_data, v.exp_resp_data);
        end
    endtask

    task automatic run_vectors(input string name);
        cur_test = name;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end
        vecs.delete();
    endtask

    // Valids are held high across reset and INIT to prove nothing is granted early.
    task automatic reset_and_init(input string name);
        cur_test = name;
        @(negedge clock);
        reset      = 1'b1;
        rd_valid   = 1'b1;
        wr_valid   = 1'b1;
        rd_addr    = 6'd7;
        wr_addr    = 6'd8;
        wr_data    = 32'hFFFF_FFFF;
        resp_ready = 1'b1;
        @(negedge clock);
        #1;
        check_val("rst_ceb", 0, 32'(sram_ceb), 32'd1);
        check_val("rst_web", 0, 32'(sram_web), 32'd1);
        check_val("rst_a", 0, 32'(sram_a), 32'd0);
        check_val("rst_d", 0, sram_d, 32'd0);
        check_val("rst_rd_ready", 0, 32'(rd_ready), 32'd0);
        check_val("rst_wr_ready", 0, 32'(wr_ready), 32'd0);
        check_val("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
        check_val("rst_init_done", 0, 32'(init_done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
`ifdef SRAM_PORT_ARBITER_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check_val("init_done_low", i, 32'(init_done), 32'd0);
            check_val("init_rd_ready", i, 32'(rd_ready), 32'd0);
            check_val("init_wr_ready", i, 32'(wr_ready), 32'd0);
            check_val("init_ceb", i, 32'(sram_ceb), 32'd0);
            check_val("init_web", i, 32'(sram_web), 32'd0);
            check_val("init_a", i, 32'(sram_a), 32'(i));
            check_val("init_d", i, sram_d, 32'd0);
            @(negedge clock);
        end
`endif
        #1;
        check_val("init_done_high", 0, 32'(init_done), 32'd1);
        rd_valid   = 1'b0;
        wr_valid   = 1'b0;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_and_init("reset1");

`ifdef SRAM_PORT_ARBITER_INIT_EN
        vecs.push_back(mk(1, 6'd0,  0, 6'd0, 32'd0, 1, GNT_RD,   0, 32'd0));
        vecs.push_back(mk(1, 6'd17, 0, 6'd0, 32'd0, 1, GNT_RD,   0, 32'd0));
        vecs.push_back(mk(1, 6'd63, 0, 6'd0, 32'd0, 1, GNT_RD,   1, 32'd0));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0, 32'd0, 1, GNT_NONE, 1, 32'd0));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0, 32'd0, 1, GNT_NONE, 1, 32'd0));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0, 32'd0, 1, GNT_NONE, 0, 32'd0));
        run_vectors("init_sweep");
`endif

        // Write then read the same address on the next cycle.
        vecs.push_back(mk(0, 6'd0, 1, 6'd5, 32'hDEAD_BEEF, 1, GNT_WR,   0, 32'd0));
        vecs.push_back(mk(1, 6'd5, 0, 6'd0, 32'd0,         1, GNT_RD,   0, 32'd0));
        vecs.push_back(mk(0, 6'd0, 0, 6'd0, 32'd0,         1, GNT_NONE, 0, 32'd0));
        vecs.push_back(mk(0, 6'd0, 0, 6'd0, 32'd0,         1, GNT_NONE, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 6'd0, 0, 6'd0, 32'd0,         1, GNT_NONE, 0, 32'd0));
        run_vectors("wr_then_rd");

        reset_and_init("reset2");
        vecs.push_back(mk(1, 6'd3, 1, 6'd9, 32'h9000_0000, 1, GNT_RD,   0, 32'd0));
        vecs.push_back(mk(1, 6'd3, 1, 6'd9, 32'h9000_0001, 1, GNT_WR,   0, 32'd0));
        vecs.push_back(mk(1, 6'd3, 1, 6'd9, 32'h9000_0002, 1, GNT_RD,   1, MEM3));
        vecs.push_back(mk(1, 6'd3, 1, 6'd9, 32'h9000_0003, 1, GNT_WR,   0, 32'd0));
        vecs.push_back(mk(1, 6'd3, 1, 6'd9, 32'h9000_0004, 1, GNT_RD,   1, MEM3));
        vecs.push_back(mk(1, 6'd3, 1, 6'd9, 32'h9000_0005, 1, GNT_WR,   0, 32'd0));
        vecs.push_back(mk(0, 6'd0, 0, 6'd0, 32'd0,         1, GNT_NONE, 1, MEM3));
        vecs.push_back(mk(0, 6'd0, 0, 6'd0, 32'd0,         1, GNT_NONE, 0, 32'd0));
        run_vectors("round_robin");

        // Backpressure: two reads fit, the rest wait while writes keep flowing.
        for (int a = 10; a < 14; a++) begin
            vecs.push_back(mk(0, 6'd0, 1, 6'(a), 32'hC0DE_0000 | 32'(a), 0, GNT_WR, 0, 32'd0));
        end
        vecs.push_back(mk(1, 6'd10, 0, 6'd0,  32'd0,         0, GNT_RD,   0, 32'd0));
        vecs.push_back(mk(1, 6'd11, 0, 6'd0,  32'd0,         0, GNT_RD,   0, 32'd0));
        vecs.push_back(mk(1, 6'd12, 0, 6'd0,  32'd0,         0, GNT_NONE, 1, 32'hC0DE_000A));
        vecs.push_back(mk(1, 6'd12, 0, 6'd0,  32'd0,         0, GNT_NONE, 1, 32'hC0DE_000A));
        vecs.push_back(mk(1, 6'd12, 1, 6'd20, 32'h2020_2020, 0, GNT_WR,   1, 32'hC0DE_000A));
        vecs.push_back(mk(1, 6'd12, 1, 6'd21, 32'h2121_2121, 0, GNT_WR,   1, 32'hC0DE_000A));
        vecs.push_back(mk(1, 6'd12, 1, 6'd22, 32'h2222_2222, 0, GNT_WR,   1, 32'hC0DE_000A));
        vecs.push_back(mk(1, 6'd12, 0, 6'd0,  32'd0,         1, GNT_RD,   1, 32'hC0DE_000A));
        vecs.push_back(mk(1, 6'd13, 0, 6'd0,  32'd0,         1, GNT_RD,   1, 32'hC0DE_000B));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0,  32'd0,         1, GNT_NONE, 1, 32'hC0DE_000C));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0,  32'd0,         1, GNT_NONE, 1, 32'hC0DE_000D));
        vecs.push_back(mk(1, 6'd20, 0, 6'd0,  32'd0,         1, GNT_RD,   0, 32'd0));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0,  32'd0,         1, GNT_NONE, 0, 32'd0));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0,  32'd0,         1, GNT_NONE, 1, 32'h2020_2020));
        vecs.push_back(mk(0, 6'd0,  0, 6'd0,  32'd0,         1, GNT_NONE, 0, 32'd0));
        run_vectors("backpressure");

        // Reset with one read in flight and one response queued.
        vecs.push_back(mk(1, 6'd10, 0, 6'd0, 32'd0, 0, GNT_RD, 0, 32'd0));
        vecs.push_back(mk(1, 6'd11, 0, 6'd0, 32'd0, 0, GNT_RD, 0, 32'd0));
        run_vectors("midop_setup");
        cur_test = "midop_reset";
        @(negedge clock);
        reset    = 1'b1;
        rd_valid = 1'b0;
        #1;
        check_val("resp_valid_in_reset", 0, 32'(resp_valid), 32'd0);
        reset_and_init("midop_reinit");
        cur_test = "midop_after";
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            check_val("no_stale_resp", i, 32'(resp_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
